// File: rtl/stw_diag_responder.sv
// stw_diag_responder: STW diagnosis responder; latches a test vector, sweeps the MAC
// array column by column and publishes a per-MAC pass/fail map plus completion flag.
module stw_diag_responder #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int WORD_SIZE   = 16,
    parameter int MAC_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           STW_test_load_en,
    input  logic [WORD_SIZE-1:0]           STW_mult_op1,
    input  logic [WORD_SIZE-1:0]           STW_mult_op2,
    input  logic [WORD_SIZE-1:0]           STW_add_op,
    input  logic [WORD_SIZE-1:0]           STW_expected,
    input  logic                           STW_start,
    input  logic [ROWS*COLS*WORD_SIZE-1:0] mac_result_bus,
    output logic                           stw_mode,
    output logic [COLS-1:0]                stw_col_sel,
    output logic [WORD_SIZE-1:0]           stw_op1,
    output logic [WORD_SIZE-1:0]           stw_op2,
    output logic [WORD_SIZE-1:0]           stw_add,
    output logic [ROWS*COLS-1:0]           STW_result_mat,
    output logic                           STW_complete_out,
    output logic                           stw_busy,
    output logic                           stw_vec_err
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, COMPARE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [NW-1:0]          cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   op1_q, op1_d, op2_q, op2_d, add_q, add_d, exp_q, exp_d;
    logic                   loaded_q, loaded_d, vec_err_q, vec_err_d, complete_q, complete_d;
    logic [ROWS*COLS-1:0]   res_q, res_d;
    logic                   idle_like, load_acc, start_acc;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign load_acc  = idle_like && STW_test_load_en;
    assign start_acc = idle_like && STW_start && loaded_q && !STW_test_load_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            cnt_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            add_q      <= '0;
            exp_q      <= '0;
            loaded_q   <= 1'b0;
            vec_err_q  <= 1'b0;
            complete_q <= 1'b0;
            res_q      <= '1;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            add_q      <= add_d;
            exp_q      <= exp_d;
            loaded_q   <= loaded_d;
            vec_err_q  <= vec_err_d;
            complete_q <= complete_d;
            res_q      <= res_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        add_d      = add_q;
        exp_d      = exp_q;
        loaded_d   = loaded_q;
        vec_err_d  = vec_err_q;
        complete_d = complete_q;
        res_d      = res_q;
        if (load_acc) begin
            op1_d      = STW_mult_op1;
            op2_d      = STW_mult_op2;
            add_d      = STW_add_op;
            exp_d      = STW_expected;
            loaded_d   = 1'b1;
            vec_err_d  = (WORD_SIZE'(STW_mult_op1 * STW_mult_op2) + STW_add_op) != STW_expected;
            complete_d = 1'b0;
            state_d    = IDLE;
        end else if (start_acc) begin
            state_d    = APPLY;
            col_d      = '0;
            cnt_d      = '0;
            complete_d = 1'b0;
        end else if (state_q == DONE) begin
            complete_d = 1'b1;
        end
        if (state_q == APPLY) begin
            cnt_d   = cnt_q + NW'(1);
            state_d = (cnt_q == NW'(MAC_LATENCY - 1)) ? COMPARE : APPLY;
        end
        // Only the column under test is rewritten; the rest of the map holds.
        if (state_q == COMPARE) begin
            for (int r = 0; r < ROWS; r++)
                res_d[r*COLS + int'(col_q)] =
                    mac_result_bus[(r*COLS + int'(col_q))*WORD_SIZE +: WORD_SIZE] == exp_q;
            state_d = (col_q == CW'(COLS - 1)) ? DONE : APPLY;
            col_d   = (col_q == CW'(COLS - 1)) ? col_q : col_q + CW'(1);
            cnt_d   = '0;
        end
    end

    always_comb begin
        stw_busy         = (state_q == APPLY) || (state_q == COMPARE);
        stw_mode         = stw_busy;
        stw_col_sel      = stw_busy ? (COLS'(1) << col_q) : '0;
        stw_op1          = op1_q;
        stw_op2          = op2_q;
        stw_add          = add_q;
        STW_result_mat   = res_q;
        STW_complete_out = complete_q;
        stw_vec_err      = vec_err_q;
    end
endmodule

// File: tb/tb_stw_diag_responder.sv
// tb_stw_diag_responder: scoreboard bench for stw_diag_responder with a behavioural MAC array model.
module tb_stw_diag_responder;
    localparam int R = 4, C = 4, W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             STW_test_load_en = 1'b0;
    logic [W-1:0]     STW_mult_op1 = '0, STW_mult_op2 = '0, STW_add_op = '0, STW_expected = '0;
    logic             STW_start = 1'b0;
    logic [R*C*W-1:0] mac_result_bus;
    logic             stw_mode, STW_complete_out, stw_busy, stw_vec_err;
    logic [C-1:0]     stw_col_sel;
    logic [W-1:0]     stw_op1, stw_op2, stw_add;
    logic [R*C-1:0]   STW_result_mat;
    logic [R*C-1:0]   fault = '0;

    typedef struct {logic [R*C-1:0] mat; int lat;} exp_t;
    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;

    stw_diag_responder dut (
        .clk(clk), .rst(rst), .STW_test_load_en(STW_test_load_en),
        .STW_mult_op1(STW_mult_op1), .STW_mult_op2(STW_mult_op2), .STW_add_op(STW_add_op),
        .STW_expected(STW_expected), .STW_start(STW_start), .mac_result_bus(mac_result_bus),
        .stw_mode(stw_mode), .stw_col_sel(stw_col_sel), .stw_op1(stw_op1), .stw_op2(stw_op2),
        .stw_add(stw_add), .STW_result_mat(STW_result_mat), .STW_complete_out(STW_complete_out),
        .stw_busy(stw_busy), .stw_vec_err(stw_vec_err)
    );

    always #5 clk = ~clk;

    // MAC array model: selected column computes op1*op2+add, faulty MACs stuck at 0xFFFF.
    always_comb begin
        mac_result_bus = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (stw_col_sel[c])
                    mac_result_bus[(r*C+c)*W +: W] = fault[r*C+c] ? 16'hFFFF : W'(stw_op1 * stw_op2 + stw_add);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d, input logic [W-1:0] e);
        STW_mult_op1 = a; STW_mult_op2 = b; STW_add_op = d; STW_expected = e;
        STW_test_load_en = 1'b1;
        step();
        STW_test_load_en = 1'b0;
    endtask

    // Pulses start and runs until completion; optionally injects a load+start at edge 4.
    task automatic sweep(input bit inject, output int lat, output int busy_cnt, output bit to);
        lat = -1; busy_cnt = 0; to = 1'b0;
        STW_start = 1'b1;
        do begin
            step();
            STW_start = 1'b0;
            STW_test_load_en = 1'b0;
            lat++;
            if (stw_busy) busy_cnt++;
            if (inject && lat == 4) begin
                STW_mult_op1 = 16'd9; STW_mult_op2 = 16'd9; STW_add_op = 16'd9; STW_expected = 16'd90;
                STW_test_load_en = 1'b1;
                STW_start = 1'b1;
            end
        end while (!STW_complete_out && lat < 100);
        to = !STW_complete_out;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        n_checks++; if (STW_result_mat !== 16'hFFFF) begin n_fail++; $display("FAIL reset_mat got %h want ffff", STW_result_mat); end
        n_checks++; if ({stw_mode, stw_col_sel, STW_complete_out, stw_busy, stw_vec_err} !== 8'd0) begin n_fail++; $display("FAIL reset_ctl got %b want 0", {stw_mode, stw_col_sel, STW_complete_out, stw_busy, stw_vec_err}); end
        n_checks++; if ({stw_op1, stw_op2, stw_add} !== 48'd0) begin n_fail++; $display("FAIL reset_ops got %h want 0", {stw_op1, stw_op2, stw_add}); end
    endtask

    task automatic test_start_no_load();
        STW_start = 1'b1;
        step();
        STW_start = 1'b0;
        step();
        n_checks++; if ({stw_busy, stw_mode, STW_complete_out} !== 3'b000) begin n_fail++; $display("FAIL noload_start got %b want 000", {stw_busy, stw_mode, STW_complete_out}); end
    endtask

    task automatic test_load_start_same();
        int lat, bc; bit to; exp_t e;
        STW_start = 1'b1;
        load(16'd4, 16'd3, 16'd0, 16'd12);
        STW_start = 1'b0;
        n_checks++; if (stw_busy !== 1'b0) begin n_fail++; $display("FAIL same_cycle_busy got %b want 0", stw_busy); end
        n_checks++; if ({stw_op1, stw_op2} !== {16'd4, 16'd3}) begin n_fail++; $display("FAIL same_cycle_ops got %h want 00040003", {stw_op1, stw_op2}); end
        sb.push_back('{16'hFFFF, 13});
        sweep(1'b0, lat, bc, to);
        e = sb.pop_front();
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL same_cycle_timeout got %b want 0", to); end
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL same_cycle_lat got %0d want %0d", lat, e.lat); end
        n_checks++; if (STW_result_mat !== e.mat) begin n_fail++; $display("FAIL same_cycle_mat got %h want %h", STW_result_mat, e.mat); end
    endtask

    task automatic test_fault_free();
        int lat, bc; bit to; exp_t e;
        load(16'd4, 16'd3, 16'd0, 16'd12);
        n_checks++; if ({stw_vec_err, STW_complete_out} !== 2'b00) begin n_fail++; $display("FAIL ff_load got %b want 00", {stw_vec_err, STW_complete_out}); end
        sb.push_back('{16'hFFFF, 13});
        sweep(1'b0, lat, bc, to);
        e = sb.pop_front();
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL ff_timeout got %b want 0", to); end
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL ff_lat got %0d want %0d", lat, e.lat); end
        n_checks++; if (bc !== 12) begin n_fail++; $display("FAIL ff_busy_cycles got %0d want 12", bc); end
        n_checks++; if (STW_result_mat !== e.mat) begin n_fail++; $display("FAIL ff_mat got %h want %h", STW_result_mat, e.mat); end
        step();
        n_checks++; if ({STW_complete_out, stw_mode, stw_col_sel} !== 6'b100000) begin n_fail++; $display("FAIL ff_done_hold got %b want 100000", {STW_complete_out, stw_mode, stw_col_sel}); end
    endtask

    task automatic test_faults();
        int lat, bc; bit to; exp_t e;
        fault = '0;
        fault[1*C+1] = 1'b1; fault[2*C+2] = 1'b1; fault[3*C+3] = 1'b1;
        sb.push_back('{~fault, 13});
        sb.push_back('{16'hFFFF, 13});
        sweep(1'b0, lat, bc, to);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL faults_lat got %0d want %0d", lat, e.lat); end
        n_checks++; if (STW_result_mat !== e.mat) begin n_fail++; $display("FAIL faults_mat got %h want %h", STW_result_mat, e.mat); end
        fault = '0;
        sweep(1'b0, lat, bc, to);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL refix_lat got %0d want %0d", lat, e.lat); end
        n_checks++; if (STW_result_mat !== e.mat) begin n_fail++; $display("FAIL refix_mat got %h want %h", STW_result_mat, e.mat); end
    endtask

    task automatic test_ignored_during_sweep();
        int lat, bc; bit to; exp_t e;
        sb.push_back('{16'hFFFF, 13});
        sweep(1'b1, lat, bc, to);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL busy_ignore_lat got %0d want %0d", lat, e.lat); end
        n_checks++; if (STW_result_mat !== e.mat) begin n_fail++; $display("FAIL busy_ignore_mat got %h want %h", STW_result_mat, e.mat); end
        n_checks++; if ({stw_op1, stw_op2, stw_add} !== {16'd4, 16'd3, 16'd0}) begin n_fail++; $display("FAIL busy_ignore_ops got %h want 000400030000", {stw_op1, stw_op2, stw_add}); end
    endtask

    task automatic test_vec_err();
        load(16'hFFFF, 16'h0002, 16'h0003, 16'h0001);
        n_checks++; if (stw_vec_err !== 1'b0) begin n_fail++; $display("FAIL vec_wrap got %b want 0", stw_vec_err); end
        load(16'hFFFF, 16'h0002, 16'h0003, 16'h0002);
        n_checks++; if (stw_vec_err !== 1'b1) begin n_fail++; $display("FAIL vec_bad got %b want 1", stw_vec_err); end
    endtask

    task automatic test_reset_mid_sweep();
        load(16'd4, 16'd3, 16'd0, 16'd12);
        fault = '0;
        fault[1*C+1] = 1'b1;
        STW_start = 1'b1;
        step();
        STW_start = 1'b0;
        repeat (8) step();
        n_checks++; if ({stw_mode, stw_col_sel} !== 5'b10100) begin n_fail++; $display("FAIL mid_col2 got %b want 10100", {stw_mode, stw_col_sel}); end
        n_checks++; if (STW_result_mat !== 16'hFFDF) begin n_fail++; $display("FAIL mid_partial got %h want ffdf", STW_result_mat); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        fault = '0;
        n_checks++; if (STW_result_mat !== 16'hFFFF) begin n_fail++; $display("FAIL mid_reset_mat got %h want ffff", STW_result_mat); end
        n_checks++; if ({stw_mode, stw_col_sel, STW_complete_out, stw_busy, stw_vec_err, stw_op1, stw_op2, stw_add} !== 56'd0) begin n_fail++; $display("FAIL mid_reset_outs got %h want 0", {stw_mode, stw_col_sel, STW_complete_out, stw_busy, stw_vec_err, stw_op1, stw_op2, stw_add}); end
        STW_start = 1'b1;
        step();
        STW_start = 1'b0;
        n_checks++; if ({stw_busy, stw_mode} !== 2'b00) begin n_fail++; $display("FAIL mid_unloaded_start got %b want 00", {stw_busy, stw_mode}); end
        step();
        n_checks++; if (STW_complete_out !== 1'b0) begin n_fail++; $display("FAIL mid_unloaded_complete got %b want 0", STW_complete_out); end
    endtask

    initial begin
        test_reset();
        test_start_no_load();
        test_load_start_same();
        test_fault_free();
        test_faults();
        test_ignored_during_sweep();
        test_vec_err();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
